mem_arbiter: RTL
================

# mem_arbiter

Shares the single-port 16-bit word RAM between two requesters: port 0 (CPU fetch/load/store path) and port 1 (program loader / debug access). One RAM access per cycle, round-robin arbitration on conflict, with a lock mode that lets port 1 hold the RAM exclusively for burst program loads while the CPU is stalled. Byte-lane writes support the CPU's high/low byte stores into 2-byte words.

## Interface
- ADDR_WIDTH, 5, word address width (32 words)
- DATA_WIDTH, 16, word width; must be 16 (two byte lanes)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- mN_req  in  1  access request, port N (N = 0, 1)
- mN_we  in  1  1 = write, 0 = read
- mN_be  in  2  byte enables: [1] = bits 15:8, [0] = bits 7:0; ignored for reads
- mN_addr  in  ADDR_WIDTH  word address
- mN_wdata  in  16  write data
- mN_gnt  out  1  request accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid (registered)
- mN_rdata  out  16  read data; 0 when mN_rvalid = 0
- m1_lock  in  1  port 1 requests exclusive ownership
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write strobe
- ram_be  out  2  RAM byte enables
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid 1 cycle after a read strobe
- conflict_cnt  out  8  saturating count of cycles where both ports requested
- locked  out  1  state is LOCKED

## Operation
- Transfer = mN_req & mN_gnt in the same cycle. Requester holds req and its fields stable until gnt.
- States: FREE, LOCKED. Pointer `last` (port granted most recently).
- FREE, one requester: granted immediately.
- FREE, both requesting: grant port != last; increment conflict_cnt (saturates at 255).
- FREE -> LOCKED: port 1 granted while m1_lock = 1.
- LOCKED: m0_gnt = 0 always; m1_gnt = m1_req. A cycle with both requesting still increments conflict_cnt.
- LOCKED -> FREE: m1_lock = 0 sampled at a clock edge. The first cycle after, FREE rules apply with last = 1, so port 0 wins a conflict.
- m1_lock asserted without a port-1 grant: no state change.
- Granted access drives ram_en = 1, ram_addr/ram_wdata from winner. ram_we = mN_we & (mN_be != 0). ram_be = mN_be on writes, 2'b00 on reads.
- Write with be = 2'b00: accepted (gnt = 1). ram_en = 1, ram_we = 0, no rvalid.
- Read: mN_rvalid = 1 in the next cycle, mN_rdata = ram_rdata in that cycle.
- No transfer: ram_en = 0, ram_we = 0, ram_be = 0, ram_addr = 0, ram_wdata = 0.
- Reads and writes are not distinguished for arbitration. Back-to-back transfers from the same port are allowed every cycle when uncontested.

## Timing
- gnt and ram_* are combinational from req/fields plus registered state/last. Zero-cycle grant.
- Read latency: exactly 1 cycle from the grant cycle to rvalid. A port granted reads on consecutive cycles gets rvalid on consecutive cycles.
- rvalid never asserts on both ports in the same cycle.
- Reset (rst = 0 at an edge) values:
  - state = FREE, last = 1, conflict_cnt = 0, locked = 0.
  - mN_rvalid = 0; a pending read response is dropped.
  - While rst = 0: all gnt = 0, ram_en = 0, ram_we = 0.
- Simultaneous m1_lock fall and m0_req: exit takes effect at the edge. Port 0 is granted in the following cycle if still requesting.
- conflict_cnt holds at 255; clears only on reset.

## Test plan
- Reset, then m0 read addr 3 with RAM word 3 = 16'hABCD: m0_gnt = 1 same cycle, ram_en = 1, ram_we = 0. Next cycle m0_rvalid = 1, m0_rdata = 16'hABCD, m1_rvalid = 0.
- Both ports request continuously for 4 cycles: grants alternate m0, m1, m0, m1; conflict_cnt = 4.
- m1 write be = 2'b10, wdata = 16'h5A00, addr 7, over RAM 16'h1234: ram_we = 1, ram_be = 2'b10. Subsequent read returns 16'h5A34.
- m1_lock = 1 with m1 granted, m0_req held high for 6 cycles: locked = 1, m0_gnt = 0 throughout, conflict_cnt counts. Drop m1_lock: next cycle m0_gnt = 1.
- m0 read granted, rst = 0 at the next edge: m0_rvalid stays 0, conflict_cnt = 0, locked = 0. After release, a single m1_req is granted immediately.
- 300 conflict cycles: conflict_cnt saturates at 255, no wrap to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit word RAM between a CPU port (0) and a
// loader/debug port (1) with round-robin arbitration and a port-1 exclusive lock mode.

module mem_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic m0_gnt,
    input logic m1_gnt,
    input logic m0_rvalid,
    input logic m1_rvalid,
    input logic locked
);
    // Invariants: one RAM access per cycle, one response per cycle, no CPU grant while locked
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(m0_gnt && m1_gnt)) else $error("FAIL chk_dual_gnt observed=1 expected=0");
            assert (!(m0_rvalid && m1_rvalid)) else $error("FAIL chk_dual_rvalid observed=1 expected=0");
            assert (!(locked && m0_gnt)) else $error("FAIL chk_locked_m0_gnt observed=1 expected=0");
        end
    end
endmodule

module mem_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [1:0]            m0_be,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [1:0]            m1_be,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic                  m1_lock,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [1:0]            ram_be,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic [7:0]            conflict_cnt,
    output logic                  locked
);

    typedef enum logic [0:0] {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_r;
    logic        last_nxt_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nxt_s;
    logic        rv0_r;
    logic        rv1_r;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        both_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic write_strobe(input logic we, input logic [1:0] be);
        return we & (be != 2'b00);
    endfunction

    // Arbitration, lock FSM next state, round-robin pointer and conflict counter
    always_comb begin
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        both_s      = m0_req & m1_req;
        if (!rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    // On conflict the port that did not win last time gets the RAM
                    if (both_s) begin
                        gnt0_s = last_r;
                        gnt1_s = ~last_r;
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                    if (gnt1_s && m1_lock) begin
                        state_nxt_s = LOCKED;
                    end else begin
                        state_nxt_s = FREE;
                    end
                end
                LOCKED: begin
                    gnt0_s = 1'b0;
                    gnt1_s = m1_req;
                    if (!m1_lock) begin
                        state_nxt_s = FREE;
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = FREE;
                end
            endcase
            if (gnt0_s) begin
                last_nxt_s = 1'b0;
            end else if (gnt1_s) begin
                last_nxt_s = 1'b1;
            end else begin
                last_nxt_s = last_r;
            end
            if (both_s) begin
                cnt_nxt_s = sat_inc(cnt_r);
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end
    end

    // Steer the winner's fields onto the RAM; an idle cycle drives all zeros
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 2'b00;
        ram_addr  = {ADDR_WIDTH{1'b0}};
        ram_wdata = {DATA_WIDTH{1'b0}};
        if (gnt0_s) begin
            ram_en    = 1'b1;
            ram_we    = write_strobe(m0_we, m0_be);
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
            if (m0_we) begin
                ram_be = m0_be;
            end else begin
                ram_be = 2'b00;
            end
        end else if (gnt1_s) begin
            ram_en    = 1'b1;
            ram_we    = write_strobe(m1_we, m1_be);
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            if (m1_we) begin
                ram_be = m1_be;
            end else begin
                ram_be = 2'b00;
            end
        end else begin
            ram_en = 1'b0;
        end
    end

    // State, pointer, counter and read-response tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= FREE;
            last_r  <= 1'b1;
            cnt_r   <= 8'd0;
            rv0_r   <= 1'b0;
            rv1_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rv0_r   <= gnt0_s & ~m0_we;
            rv1_r   <= gnt1_s & ~m1_we;
        end
    end

    // A response still in flight while reset is held is suppressed, not delivered
    assign m0_gnt       = gnt0_s;
    assign m1_gnt       = gnt1_s;
    assign m0_rvalid    = rv0_r & rst;
    assign m1_rvalid    = rv1_r & rst;
    assign m0_rdata     = m0_rvalid ? ram_rdata : {DATA_WIDTH{1'b0}};
    assign m1_rdata     = m1_rvalid ? ram_rdata : {DATA_WIDTH{1'b0}};
    assign conflict_cnt = cnt_r;
    assign locked       = (state_r == LOCKED);

    mem_arbiter_checker u_checker (
        .clk       (clk),
        .rst       (rst),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .locked    (locked)
    );

endmodule
